// File: rtl/stroke_pkg.sv
// Shared definitions for the stroke path (generator and painter).
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package stroke_pkg;

  localparam int DEF_IMG_W = 64;
  localparam int DEF_IMG_H = 64;
  localparam int DEF_PIX_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Magnitude of a-b; one extra bit so the signed subtract cannot overflow.
  function automatic logic [DEF_PIX_W:0] absdiff(input logic [DEF_PIX_W-1:0] a,
                                                 input logic [DEF_PIX_W-1:0] b);
    logic signed [DEF_PIX_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[DEF_PIX_W] ? $unsigned(-d) : $unsigned(d);
  endfunction

endpackage

// File: rtl/stroke_cmp.sv
// Write decision: overwrite canvas only if colour is strictly closer to reference.
// Latency: 1 cycle from read strobe to write strobe (matches the memory read latency).
// Backpressure: none; follows the read stream one-for-one.
module stroke_cmp
  import stroke_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  input  logic [DEF_PIX_W-1:0] ref_rdata,
  input  logic [DEF_PIX_W-1:0] cv_rdata,
  input  logic [DEF_PIX_W-1:0] color,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr
);

  logic vld_q;

  // Track which read returns data this cycle and where it came from.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q   <= 1'b0;
      wr_addr <= '0;
    end else begin
      vld_q   <= rd_en;
      wr_addr <= rd_addr;
    end
  end

  // Ties keep the existing canvas value.
  assign wr_en = vld_q && (absdiff(ref_rdata, color) < absdiff(ref_rdata, cv_rdata));

endmodule

// File: rtl/stroke_paint.sv
// Rasterizes a clipped square brush around each stroke point into the canvas.
// Latency: N footprint reads in cycles 1..N, last write in N+1, ready again in N+2.
// Backpressure: in_ready low from acceptance until the compare pipeline drains.
module stroke_paint
  import stroke_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [$clog2(IMG_W)-1:0]      in_x,
  input  logic [$clog2(IMG_H)-1:0]      in_y,
  input  logic [2:0]                    in_radius,
  input  logic [PIX_W-1:0]              in_color,
  input  logic                          in_last,
  output logic                          rd_en,
  output logic [$clog2(IMG_W*IMG_H)-1:0] rd_addr,
  input  logic [PIX_W-1:0]              cv_rdata,
  input  logic [PIX_W-1:0]              ref_rdata,
  output logic                          wr_en,
  output logic [$clog2(IMG_W*IMG_H)-1:0] wr_addr,
  output logic [PIX_W-1:0]              wr_data,
  output logic                          done,
  output logic [15:0]                   wr_count
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int AW = $clog2(IMG_W*IMG_H);

  state_t           state;
  logic [XW-1:0]    cur_x, x_lo, x_hi;
  logic [YW-1:0]    cur_y, y_hi;
  logic [PIX_W-1:0] color_q;
  logic             last_q;
  logic             new_stroke;
  logic             accept;

  logic signed [XW+1:0] xs_lo, xs_hi;
  logic signed [YW+1:0] ys_lo, ys_hi;
  logic [XW-1:0]        x_lo_n, x_hi_n;
  logic [YW-1:0]        y_lo_n, y_hi_n;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign rd_en    = (state == SCAN);
  // IMG_W is a power of two, so y*IMG_W+x is a plain concatenation.
  assign rd_addr  = {cur_y, cur_x};
  assign done     = (state == DRAIN) && last_q;
  assign wr_data  = color_q;

  // Clip the footprint to the image using signed bounds around the incoming point.
  always_comb begin
    xs_lo  = $signed({2'b00, in_x}) - $signed((XW+2)'(in_radius));
    xs_hi  = $signed({2'b00, in_x}) + $signed((XW+2)'(in_radius));
    ys_lo  = $signed({2'b00, in_y}) - $signed((YW+2)'(in_radius));
    ys_hi  = $signed({2'b00, in_y}) + $signed((YW+2)'(in_radius));
    x_lo_n = (xs_lo < 0) ? '0 : XW'(xs_lo);
    x_hi_n = (xs_hi > $signed((XW+2)'(IMG_W-1))) ? XW'(IMG_W-1) : XW'(xs_hi);
    y_lo_n = (ys_lo < 0) ? '0 : YW'(ys_lo);
    y_hi_n = (ys_hi > $signed((YW+2)'(IMG_H-1))) ? YW'(IMG_H-1) : YW'(ys_hi);
  end

  // Point latch and row-major footprint walk; one read per SCAN cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cur_x   <= '0;
      cur_y   <= '0;
      x_lo    <= '0;
      x_hi    <= '0;
      y_hi    <= '0;
      color_q <= '0;
      last_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            x_lo    <= x_lo_n;
            x_hi    <= x_hi_n;
            y_hi    <= y_hi_n;
            cur_x   <= x_lo_n;
            cur_y   <= y_lo_n;
            color_q <= in_color;
            last_q  <= in_last;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (cur_x == x_hi) begin
            cur_x <= x_lo;
            if (cur_y == y_hi) state <= DRAIN;
            else               cur_y <= cur_y + YW'(1);
          end else begin
            cur_x <= cur_x + XW'(1);
          end
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Per-stroke write counter; restarts on the first point after a finished stroke.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count   <= '0;
      new_stroke <= 1'b1;
    end else begin
      if (accept && new_stroke) begin
        wr_count   <= '0;
        new_stroke <= 1'b0;
      end else if (wr_en && wr_count != 16'hFFFF) begin
        wr_count <= wr_count + 16'd1;
      end
      if (done) new_stroke <= 1'b1;
    end
  end

  stroke_cmp #(.AW(AW)) u_cmp (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .ref_rdata (ref_rdata),
    .cv_rdata  (cv_rdata),
    .color     (color_q),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr)
  );

endmodule

// File: doc/stroke_paint.md
# stroke_paint

Consumer end of the stroke path. Accepts stroke control points from the stroke generator over a valid/ready handshake and rasterizes a square brush footprint around each point into the canvas memory. A pixel is overwritten only when the stroke colour is strictly closer to the reference image than the current canvas value. Sits between the stroke generator and the canvas/reference frame buffers.

## Interface
- IMG_W, 64, image width in pixels (power of two)
- IMG_H, 64, image height in pixels
- PIX_W, 8, pixel/colour width (grayscale)
- AW, $clog2(IMG_W*IMG_H), memory address width (derived)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  point valid
- in_ready  out  1  block can accept a point
- in_x  in  $clog2(IMG_W)  point column
- in_y  in  $clog2(IMG_H)  point row
- in_radius  in  3  brush half-width r (0..7)
- in_color  in  PIX_W  stroke colour
- in_last  in  1  final point of the current stroke
- rd_en  out  1  canvas+reference read strobe
- rd_addr  out  AW  read address, y*IMG_W+x
- cv_rdata  in  PIX_W  canvas data, valid one cycle after rd_en
- ref_rdata  in  PIX_W  reference data, same address and latency as cv_rdata
- wr_en  out  1  canvas write strobe
- wr_addr  out  AW  write address
- wr_data  out  PIX_W  write data (always the latched colour)
- done  out  1  one-cycle pulse when the in_last point has fully retired
- wr_count  out  16  canvas writes in the current stroke, saturating

## Operation
- Reset values: in_ready=1, rd_en=0, wr_en=0, done=0, wr_count=0, rd_addr/wr_addr/wr_data=0, state IDLE.
- FSM states: IDLE, SCAN, DRAIN.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch x, y, r, colour, last, then go to SCAN.
  - SCAN: issue one read per cycle, row-major. Footprint columns x_lo..x_hi, rows y_lo..y_hi.
    - x_lo = max(0, x-r), x_hi = min(IMG_W-1, x+r), computed signed. Rows clip the same way.
    - After the read of (x_hi, y_hi), go to DRAIN.
  - DRAIN: one cycle for the final compare/write, then IDLE.
- Compare stage, one cycle after each read: write when |ref-colour| < |ref-canvas|.
  - Differences are computed at PIX_W+1 bits signed, then magnitudes are compared unsigned.
  - Ties do not write.
- No read-after-write hazard inside a point, because footprint addresses are distinct. in_ready stays low until the pipeline drains, so consecutive points never overlap.
- wr_count: cleared on acceptance of the first point after done (or after reset). Incremented per write and saturates at 16'hFFFF. It holds its value after done until the next stroke starts.
- done is asserted in the DRAIN→IDLE cycle of a point latched with in_last=1.
- A reset assertion at any time aborts the scan immediately. No further rd_en/wr_en is issued, and the point is lost.

## Timing
- The point is accepted at the edge ending cycle 0. Footprint size is N = (x_hi-x_lo+1)*(y_hi-y_lo+1).
- rd_en is high in cycles 1..N. The read address for pixel k appears in cycle k.
- A write for pixel k, if any, appears in cycle k+1. wr_addr equals the rd_addr of the previous cycle.
- in_ready is low in cycles 1..N+1 and high again in cycle N+2. done is high in cycle N+1 for a last point.
- Peak throughput is one pixel per cycle. Per-point overhead is 2 cycles.
- in_x/in_y/in_radius/in_color/in_last are ignored while in_ready=0. The upstream block holds them stable with in_valid.

## Structure
- Package stroke_pkg contains:
  - IMG_W/IMG_H/PIX_W defaults
  - state enum {IDLE, SCAN, DRAIN}
  - an absdiff function (PIX_W+1-bit signed subtract, magnitude return)
- This package is shared with the stroke generator.
- Sub-module stroke_cmp: registered comparator taking ref, canvas and colour, outputting the write decision. Latency 1 cycle.

## Test plan
- Single pixel: point (10,10), r=0, colour 90, ref 100, canvas 0 → wr_en in cycle 2 with wr_addr 650, wr_data 90. in_ready returns in cycle 3. wr_count=1.
- Tie/no-write: ref 50, canvas 40, colour 60 (diffs 10 vs 10) → rd_en pulses but there is no wr_en. wr_count stays 0.
- Top-left clip: (0,0), r=2 → 9 reads at addresses 0,1,2,64,65,66,128,129,130. in_ready returns in cycle 11.
- Bottom-right clip: (63,63), r=3 → 16 reads with addresses from 3900 through 4095. With canvas all 255, ref 0 and colour 0 there are 16 writes.
- Two-point stroke: in_valid held high during the first point's scan, second point has in_last=1 → the second point is accepted only when in_ready returns. done pulses exactly once, after the second point's last write. The third stroke's first point clears wr_count.
- Reset mid-scan: (20,20), r=7, deassert rst in cycle 30 → rd_en/wr_en drop immediately and all outputs take reset values. After release, a new point is accepted normally.
